// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ps2_pkg
// Brief    : Set-2 scan-code constants, decoder state and key-event types.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXT    = 2'd1,
        BRK    = 2'd2,
        EXTBRK = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // Keyboard status/response bytes that never describe a key.
    function automatic logic is_discard(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_discard = 1'b1;
            default:                                          is_discard = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_evt_fifo
// Brief    : Power-of-2 event FIFO with valid/ready pop, occupancy and full.
// Revision : 1.0
// ============================================================================
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                       kbd_clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);

    localparam int                 c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]      c_DEPTH = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic [WIDTH-1:0] r_hold;

    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic [WIDTH-1:0] w_head;

    assign w_empty = (r_count == '0);
    assign o_full  = (r_count == c_DEPTH);
    assign w_pop   = !w_empty && i_ready;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);
    assign w_head  = w_empty ? r_hold : r_mem[r_rd_ptr];

    assign o_valid = !w_empty;
    assign o_data  = w_head;
    assign o_count = r_count;

    always_ff @(posedge kbd_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge kbd_clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            r_hold <= w_head;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_fifo
// Brief    : Set-2 prefix decoder, held-key repeat filter and event queue.
// Revision : 1.0
// ============================================================================
module ps2_scancode_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int FILTER_REPEAT = 1,
    parameter int ENABLE_EXT    = 1
) (
    input  logic                          kbd_clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_code,
    output logic                          out_brk,
    output logic                          out_ext,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          err
);

    dec_state_t   r_state;
    dec_state_t   w_state_nxt;
    logic [511:0] r_held;
    logic         r_ovf;
    logic         r_err;

    ps2_evt_t     w_evt;
    ps2_evt_t     w_head;
    logic         w_evt_vld;
    logic         w_err;
    logic         w_is_e0;
    logic         w_is_f0;
    logic         w_is_disc;
    logic [8:0]   w_idx;
    logic         w_emit;
    logic         w_full;
    logic         w_pop;
    logic         w_drop;

    assign w_is_e0   = (in_data == PS2_EXT);
    assign w_is_f0   = (in_data == PS2_BRK);
    assign w_is_disc = is_discard(in_data);

    always_comb begin
        w_state_nxt = r_state;
        w_evt_vld   = 1'b0;
        w_evt       = '0;
        w_err       = 1'b0;
        if (in_valid) begin
            case (r_state)
                IDLE: begin
                    if (w_is_e0) begin
                        if (ENABLE_EXT != 0)
                            w_state_nxt = EXT;
                    end else if (w_is_f0) begin
                        w_state_nxt = BRK;
                    end else if (!w_is_disc) begin
                        w_evt_vld = 1'b1;
                        w_evt     = '{ext: 1'b0, brk: 1'b0, code: in_data};
                    end
                end
                EXT: begin
                    if (w_is_f0) begin
                        w_state_nxt = EXTBRK;
                    end else if (w_is_e0) begin
                        w_err = 1'b1;
                    end else if (w_is_disc) begin
                        w_err       = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_evt_vld   = 1'b1;
                        w_evt       = '{ext: 1'b1, brk: 1'b0, code: in_data};
                        w_state_nxt = IDLE;
                    end
                end
                BRK: begin
                    if (w_is_f0) begin
                        w_err = 1'b1;
                    end else if (w_is_e0) begin
                        // Without extended decoding an E0 is invisible here too.
                        if (ENABLE_EXT != 0) begin
                            w_err       = 1'b1;
                            w_state_nxt = EXT;
                        end
                    end else if (w_is_disc) begin
                        w_err       = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_evt_vld   = 1'b1;
                        w_evt       = '{ext: 1'b0, brk: 1'b1, code: in_data};
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    if (w_is_e0) begin
                        w_err       = 1'b1;
                        w_state_nxt = EXT;
                    end else if (w_is_f0) begin
                        w_err       = 1'b1;
                        w_state_nxt = BRK;
                    end else if (w_is_disc) begin
                        w_err       = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_evt_vld   = 1'b1;
                        w_evt       = '{ext: 1'b1, brk: 1'b1, code: in_data};
                        w_state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    assign w_idx  = {w_evt.ext, w_evt.code};
    assign w_emit = w_evt_vld && !((FILTER_REPEAT != 0) && !w_evt.brk && r_held[w_idx]);
    assign w_pop  = out_valid && out_ready;
    assign w_drop = w_emit && w_full && !w_pop;

    always_ff @(posedge kbd_clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_held  <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err;
            // Held state tracks the keyboard even when the event is dropped.
            if (w_evt_vld)
                r_held[w_idx] <= !w_evt.brk;
            if (w_drop)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ps2_evt_t))
    ) u_fifo (
        .kbd_clk (kbd_clk),
        .rst     (rst),
        .i_push  (w_emit),
        .i_data  (w_evt),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (w_head),
        .o_count (count),
        .o_full  (w_full)
    );

    assign out_code = w_head.code;
    assign out_brk  = w_head.brk;
    assign out_ext  = w_head.ext;
    assign overflow = r_ovf;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_scancode_fifo
// Brief    : Scoreboard bench for default, no-extended and no-filter variants.
// Revision : 1.0
// ============================================================================
module tb_ps2_scancode_fifo;

    logic       kbd_clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       va = 1'b0, vb = 1'b0, vc = 1'b0;
    logic       out_ready = 1'b0;
    logic       ovf_clr = 1'b0;

    logic       a_valid, a_brk, a_ext, a_ovf, a_err;
    logic [7:0] a_code;
    logic [3:0] a_count;
    logic       b_valid, b_brk, b_ext, b_ovf, b_err;
    logic [7:0] b_code;
    logic [3:0] b_count;
    logic       c_valid, c_brk, c_ext, c_ovf, c_err;
    logic [7:0] c_code;
    logic [3:0] c_count;

    logic [9:0] qa[$];
    logic [9:0] qb[$];
    logic [9:0] qc[$];
    int n_chk = 0;
    int n_err = 0;
    int a_errs = 0;
    int b_errs = 0;
    int c_errs = 0;

    always #5 kbd_clk = ~kbd_clk;

    ps2_scancode_fifo #(.FIFO_DEPTH(8), .FILTER_REPEAT(1), .ENABLE_EXT(1)) u_dut_a (
        .kbd_clk(kbd_clk), .rst(rst), .in_valid(va), .in_data(in_data),
        .out_valid(a_valid), .out_ready(out_ready), .out_code(a_code), .out_brk(a_brk),
        .out_ext(a_ext), .count(a_count), .overflow(a_ovf), .ovf_clr(ovf_clr), .err(a_err));

    ps2_scancode_fifo #(.FIFO_DEPTH(8), .FILTER_REPEAT(1), .ENABLE_EXT(0)) u_dut_b (
        .kbd_clk(kbd_clk), .rst(rst), .in_valid(vb), .in_data(in_data),
        .out_valid(b_valid), .out_ready(out_ready), .out_code(b_code), .out_brk(b_brk),
        .out_ext(b_ext), .count(b_count), .overflow(b_ovf), .ovf_clr(ovf_clr), .err(b_err));

    ps2_scancode_fifo #(.FIFO_DEPTH(8), .FILTER_REPEAT(0), .ENABLE_EXT(1)) u_dut_c (
        .kbd_clk(kbd_clk), .rst(rst), .in_valid(vc), .in_data(in_data),
        .out_valid(c_valid), .out_ready(out_ready), .out_code(c_code), .out_brk(c_brk),
        .out_ext(c_ext), .count(c_count), .overflow(c_ovf), .ovf_clr(ovf_clr), .err(c_err));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every handshake pops the oldest expected event.
    always @(negedge kbd_clk) begin
        if (rst && a_valid && out_ready) begin
            if (qa.size() == 0) chk("a_unexpected", {a_ext, a_brk, a_code}, 32'hFFFF);
            else                chk("a_event", {a_ext, a_brk, a_code}, qa.pop_front());
        end
        if (rst && b_valid && out_ready) begin
            if (qb.size() == 0) chk("b_unexpected", {b_ext, b_brk, b_code}, 32'hFFFF);
            else                chk("b_event", {b_ext, b_brk, b_code}, qb.pop_front());
        end
        if (rst && c_valid && out_ready) begin
            if (qc.size() == 0) chk("c_unexpected", {c_ext, c_brk, c_code}, 32'hFFFF);
            else                chk("c_event", {c_ext, c_brk, c_code}, qc.pop_front());
        end
        if (a_err) a_errs++;
        if (b_err) b_errs++;
        if (c_err) c_errs++;
    end

    // m selects which instances see the byte: bit0=a, bit1=b, bit2=c.
    task automatic send(input logic [7:0] b, input logic [2:0] m);
        in_data = b;
        va = m[0];
        vb = m[1];
        vc = m[2];
        @(posedge kbd_clk);
        #1;
        va = 1'b0;
        vb = 1'b0;
        vc = 1'b0;
    endtask

    task automatic drain();
        int i;
        out_ready = 1'b1;
        i = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && i < 200) begin
            @(posedge kbd_clk);
            i++;
        end
        @(posedge kbd_clk);
        #1;
        chk("drain_qa", qa.size(), 0);
        chk("drain_qb", qb.size(), 0);
        chk("drain_qc", qc.size(), 0);
        chk("drain_a_count", a_count, 0);
        chk("drain_c_count", c_count, 0);
    endtask

    initial begin
        int e0;
        repeat (3) @(posedge kbd_clk);
        #1;
        chk("rst_valid", a_valid, 0);
        chk("rst_code", {a_ext, a_brk, a_code}, 0);
        chk("rst_count", a_count, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_err", a_err, 0);
        rst = 1'b1;
        @(posedge kbd_clk);
        #1;

        // Make/break pairs, with N+1 visibility of the first event.
        out_ready = 1'b1;
        send(8'h1C, 3'b001); qa.push_back({2'b00, 8'h1C});
        chk("latency_valid", a_valid, 1);
        chk("latency_code", a_code, 8'h1C);
        send(8'hF0, 3'b001);
        send(8'h1C, 3'b001); qa.push_back({2'b01, 8'h1C});
        send(8'h1B, 3'b001); qa.push_back({2'b00, 8'h1B});
        send(8'hF0, 3'b001);
        send(8'h1B, 3'b001); qa.push_back({2'b01, 8'h1B});
        drain();

        // Extended key, with and without E0 decoding.
        send(8'hE0, 3'b011);
        send(8'h75, 3'b011); qa.push_back({2'b10, 8'h75}); qb.push_back({2'b00, 8'h75});
        send(8'hE0, 3'b011);
        send(8'hF0, 3'b011);
        send(8'h75, 3'b011); qa.push_back({2'b11, 8'h75}); qb.push_back({2'b01, 8'h75});
        drain();

        // Typematic repeats, filtered and unfiltered.
        send(8'h1C, 3'b101); qa.push_back({2'b00, 8'h1C}); qc.push_back({2'b00, 8'h1C});
        send(8'h1C, 3'b101); qc.push_back({2'b00, 8'h1C});
        send(8'h1C, 3'b101); qc.push_back({2'b00, 8'h1C});
        send(8'hF0, 3'b101);
        send(8'h1C, 3'b101); qa.push_back({2'b01, 8'h1C}); qc.push_back({2'b01, 8'h1C});
        send(8'h1C, 3'b101); qa.push_back({2'b00, 8'h1C}); qc.push_back({2'b00, 8'h1C});
        drain();
        chk("no_err_a", a_errs, 0);
        chk("no_err_b", b_errs, 0);

        // Overflow: two extra makes are dropped while the consumer stalls.
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            send(8'h10 + 8'(k), 3'b001);
            if (k < 8) qa.push_back({2'b00, 8'h10 + 8'(k)});
        end
        chk("ovf_count", a_count, 8);
        chk("ovf_set", a_ovf, 1);
        drain();
        chk("ovf_sticky", a_ovf, 1);
        ovf_clr = 1'b1;
        @(posedge kbd_clk);
        #1;
        ovf_clr = 1'b0;
        chk("ovf_cleared", a_ovf, 0);

        // Full queue with simultaneous push and pop.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send(8'h20 + 8'(k), 3'b001);
            qa.push_back({2'b00, 8'h20 + 8'(k)});
        end
        chk("full_count", a_count, 8);
        out_ready = 1'b1;
        send(8'h28, 3'b001); qa.push_back({2'b00, 8'h28});
        chk("pushpop_count", a_count, 8);
        chk("pushpop_ovf", a_ovf, 0);
        drain();

        // Illegal F0 F0 prefix: one err pulse, then the break still lands.
        e0 = a_errs;
        send(8'hF0, 3'b001);
        send(8'hF0, 3'b001);
        chk("err_pulse", a_err, 1);
        send(8'h1C, 3'b001); qa.push_back({2'b01, 8'h1C});
        chk("err_cleared", a_err, 0);
        drain();
        chk("err_once", a_errs - e0, 1);

        // Reset after E0 while 33 is held: prefix and bitmap both forgotten.
        send(8'h33, 3'b001); qa.push_back({2'b00, 8'h33});
        drain();
        send(8'hE0, 3'b001);
        rst = 1'b0;
        @(posedge kbd_clk);
        #1;
        chk("midrst_count", a_count, 0);
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge kbd_clk);
        #1;
        send(8'h1C, 3'b001); qa.push_back({2'b00, 8'h1C});
        chk("midrst_one", a_count, 1);
        send(8'h33, 3'b001); qa.push_back({2'b00, 8'h33});
        chk("midrst_held_cleared", a_count, 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
